// File: rtl/pb_bounce_emulator.sv
// Pushbutton bounce emulator.
// Turns a clean commanded level into a PB waveform with repeatable
// pseudo-random contact bounce. The bounce timing comes from a free-running
// 8-bit LFSR, so the same seed and stimulus always give the same waveform.
module pb_bounce_emulator #(
  parameter int         BOUNCE_LEN = 64,
  parameter int         GAP_W      = 3,
  parameter logic [7:0] SEED       = 8'hA5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cmd,
  input  logic       enable_bounce,
  output logic       PB,
  output logic       busy,
  output logic       done,
  output logic [7:0] toggles
);

  // An all-zero seed would lock the LFSR up, so it is replaced by 1.
  localparam logic [7:0] LFSR_INIT  = (SEED == 8'h00) ? 8'h01 : SEED;
  // The timer counts down to 0. The edge that sees 0 is the settling edge,
  // BOUNCE_LEN edges after the first edge of the event.
  localparam logic [7:0] TIMER_LOAD = 8'(BOUNCE_LEN - 1);

  typedef enum logic {
    IDLE,
    BOUNCE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [7:0]       lfsr;
  logic             stable;
  logic [7:0]       bounce_timer;
  logic [GAP_W:0]   gap;
  logic [GAP_W:0]   gap_next;
  logic [7:0]       tcnt;
  logic             start_clean;
  logic             start_bounce;
  logic             settle;
  logic             gap_hit;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [7:0] sat_add_bit(input logic [7:0] v, input logic b);
    return b ? sat_inc(v) : v;
  endfunction

  assign gap_next = (GAP_W+1)'(lfsr[GAP_W-1:0]) + (GAP_W+1)'(1);
  assign busy     = (state == BOUNCE);

  // Free-running Fibonacci LFSR, x^8+x^6+x^5+x^4+1, advancing every cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lfsr <= LFSR_INIT;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and per-cycle event decode.
  always_comb begin
    state_next   = state;
    start_clean  = 1'b0;
    start_bounce = 1'b0;
    settle       = 1'b0;
    gap_hit      = 1'b0;
    case (state)
      IDLE: begin
        if (cmd != stable) begin
          if (enable_bounce) begin
            start_bounce = 1'b1;
            state_next   = BOUNCE;
          end else begin
            start_clean  = 1'b1;
          end
        end
      end
      BOUNCE: begin
        // Settling has priority over a gap toggle that falls on the same edge.
        if (bounce_timer == 8'd0) begin
          settle     = 1'b1;
          state_next = IDLE;
        end else if (gap == (GAP_W+1)'(1)) begin
          gap_hit    = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // PB waveform, settled level, timers and edge accounting.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      PB           <= 1'b0;
      stable       <= 1'b0;
      done         <= 1'b0;
      toggles      <= 8'd0;
      tcnt         <= 8'd0;
      bounce_timer <= 8'd0;
      gap          <= '0;
    end else begin
      done <= 1'b0;
      if (start_clean) begin
        PB      <= cmd;
        stable  <= cmd;
        toggles <= 8'd1;
        done    <= 1'b1;
      end
      if (start_bounce) begin
        PB           <= ~PB;
        tcnt         <= 8'd1;
        bounce_timer <= TIMER_LOAD;
        gap          <= gap_next;
      end
      if (state == BOUNCE) begin
        if (settle) begin
          PB      <= cmd;
          stable  <= cmd;
          toggles <= sat_add_bit(tcnt, PB != cmd);
          done    <= 1'b1;
        end else begin
          bounce_timer <= bounce_timer - 8'd1;
          if (gap_hit) begin
            PB   <= ~PB;
            tcnt <= sat_inc(tcnt);
            gap  <= gap_next;
          end else begin
            gap  <= gap - (GAP_W+1)'(1);
          end
        end
      end
    end
  end

endmodule
